// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared state encoding, header field layout and EXEC_CYCLES limits
package alu_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_IMM  = 2'd1,
      S_EXEC = 2'd2,
      S_RESP = 2'd3
   } ctrl_state_e;

   localparam int OP_MSB    = 15;
   localparam int OP_LSB    = 13;
   localparam int SRCB_BIT  = 12;
   localparam int NB_MSB    = 11;
   localparam int NB_LSB    = 10;
   localparam int SHIFT_BIT = 9;
   localparam int IMM_MSB   = 11;

   localparam logic [15:0] RSVD_MASK = 16'h01FF;

   localparam int EXEC_MIN = 1;
   localparam int EXEC_MAX = 15;

   // Out-of-range builds are clamped so the 4-bit counter can never wrap.
   function automatic logic [3:0] exec_load(input int n);
      int c;
      c = (n < EXEC_MIN) ? EXEC_MIN : ((n > EXEC_MAX) ? EXEC_MAX : n);
      return 4'(c - 1);
   endfunction

endpackage

// File: rtl/alu_instr_decode.sv
// rtl/alu_instr_decode.sv - combinational header field split and reserved-bit check
module alu_instr_decode
   import alu_ctrl_pkg::*;
(
   input  logic [15:0] instr_in,
   output logic [2:0]  alu_op,
   output logic        src_b,
   output logic [1:0]  num_bits,
   output logic        imm_shift,
   output logic        rsvd_ok
);

   assign alu_op    = instr_in[OP_MSB:OP_LSB];
   assign src_b     = instr_in[SRCB_BIT];
   assign num_bits  = instr_in[NB_MSB:NB_LSB];
   assign imm_shift = instr_in[SHIFT_BIT];
   assign rsvd_ok   = ((instr_in & RSVD_MASK) == 16'h0000);

endmodule

// File: rtl/alu_controller.sv
// rtl/alu_controller.sv - header/immediate sequencer driving ALU controls and capturing ALUOut
module alu_controller
   import alu_ctrl_pkg::*;
#(
   parameter int EXEC_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [15:0] instr_in,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [15:0] ALUOut,
   output logic [2:0]  ALUOp,
   output logic        ALUSrcB,
   output logic [11:0] din,
   output logic [1:0]  numBits,
   output logic        immShift,
   output logic [15:0] result,
   output logic        result_valid,
   input  logic        result_ready,
   output logic        busy,
   output logic        err
);

   localparam logic [3:0] EXEC_LOAD = exec_load(EXEC_CYCLES);

   ctrl_state_e state_q;
   logic [3:0]  cnt_q;
   logic        load_q;
   logic [2:0]  op_q;
   logic        srcb_q;
   logic [11:0] din_q;
   logic [1:0]  nb_q;
   logic        sh_q;
   logic [15:0] res_q;
   logic        rv_q;
   logic        rdy_q;
   logic        busy_q;
   logic        err_q;

   logic [2:0]  dec_op;
   logic        dec_srcb;
   logic [1:0]  dec_nb;
   logic        dec_sh;
   logic        dec_rsvd_ok;
   logic        beat;

   alu_instr_decode u_decode (
      .instr_in  (instr_in),
      .alu_op    (dec_op),
      .src_b     (dec_srcb),
      .num_bits  (dec_nb),
      .imm_shift (dec_sh),
      .rsvd_ok   (dec_rsvd_ok)
   );

   assign beat = instr_valid & rdy_q;

   // load_q marks the first EXEC cycle, where the counter is loaded; this
   // gives EXEC_CYCLES+1 edges from the last accepted beat to result_valid.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         load_q  <= 1'b0;
         op_q    <= 3'd0;
         srcb_q  <= 1'b0;
         din_q   <= 12'd0;
         nb_q    <= 2'd0;
         sh_q    <= 1'b0;
         res_q   <= 16'd0;
         rv_q    <= 1'b0;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               rdy_q  <= 1'b1;
               busy_q <= 1'b0;
               if (beat) begin
                  if (!dec_rsvd_ok) begin
                     err_q <= 1'b1;
                  end else begin
                     op_q   <= dec_op;
                     srcb_q <= dec_srcb;
                     nb_q   <= dec_nb;
                     sh_q   <= dec_sh;
                     busy_q <= 1'b1;
                     if (dec_srcb) begin
                        state_q <= S_IMM;
                     end else begin
                        din_q   <= 12'd0;
                        load_q  <= 1'b1;
                        rdy_q   <= 1'b0;
                        state_q <= S_EXEC;
                     end
                  end
               end
            end
            S_IMM: begin
               if (beat) begin
                  din_q   <= instr_in[IMM_MSB:0];
                  load_q  <= 1'b1;
                  rdy_q   <= 1'b0;
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (load_q) begin
                  cnt_q  <= EXEC_LOAD;
                  load_q <= 1'b0;
               end else if (cnt_q == 4'd0) begin
                  res_q   <= ALUOut;
                  rv_q    <= 1'b1;
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_RESP: begin
               if (result_ready) begin
                  rv_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  rdy_q   <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               rdy_q   <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign instr_ready  = rdy_q;
   assign ALUOp        = op_q;
   assign ALUSrcB      = srcb_q;
   assign din          = din_q;
   assign numBits      = nb_q;
   assign immShift     = sh_q;
   assign result       = res_q;
   assign result_valid = rv_q;
   assign busy         = busy_q;
   assign err          = err_q;

endmodule

// File: tb/tb_alu_controller.sv
// tb/tb_alu_controller.sv - directed-vector bench with behavioural ALU stub
module tb_alu_controller;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [15:0] instr_in = 16'd0;
   logic        instr_valid = 1'b0;
   logic        result_ready = 1'b0;
   logic [15:0] alu_out = 16'd0;
   logic        instr_ready, ALUSrcB, immShift, result_valid, busy, err;
   logic [2:0]  ALUOp;
   logic [11:0] din;
   logic [1:0]  numBits;
   logic [15:0] result;

   logic        aux_valid = 1'b0;
   logic        aux_ready = 1'b0;
   logic [15:0] aux_alu = 16'h00A5;
   logic        r1_ready, r1_srcb, r1_sh, r1_rv, r1_busy, r1_err;
   logic [2:0]  r1_op;
   logic [11:0] r1_din;
   logic [1:0]  r1_nb;
   logic [15:0] r1_res;
   logic        r15_ready, r15_srcb, r15_sh, r15_rv, r15_busy, r15_err;
   logic [2:0]  r15_op;
   logic [11:0] r15_din;
   logic [1:0]  r15_nb;
   logic [15:0] r15_res;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   alu_controller #(.EXEC_CYCLES(2)) dut (
      .CLK(CLK), .RST_N(RST_N), .instr_in(instr_in), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .ALUOut(alu_out), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
      .din(din), .numBits(numBits), .immShift(immShift), .result(result),
      .result_valid(result_valid), .result_ready(result_ready), .busy(busy), .err(err)
   );

   alu_controller #(.EXEC_CYCLES(1)) dut1 (
      .CLK(CLK), .RST_N(RST_N), .instr_in(instr_in), .instr_valid(aux_valid),
      .instr_ready(r1_ready), .ALUOut(aux_alu), .ALUOp(r1_op), .ALUSrcB(r1_srcb),
      .din(r1_din), .numBits(r1_nb), .immShift(r1_sh), .result(r1_res),
      .result_valid(r1_rv), .result_ready(aux_ready), .busy(r1_busy), .err(r1_err)
   );

   alu_controller #(.EXEC_CYCLES(15)) dut15 (
      .CLK(CLK), .RST_N(RST_N), .instr_in(instr_in), .instr_valid(aux_valid),
      .instr_ready(r15_ready), .ALUOut(aux_alu), .ALUOp(r15_op), .ALUSrcB(r15_srcb),
      .din(r15_din), .numBits(r15_nb), .immShift(r15_sh), .result(r15_res),
      .result_valid(r15_rv), .result_ready(aux_ready), .busy(r15_busy), .err(r15_err)
   );

   // Behavioural datapath: registered one cycle after the controls.
   always @(posedge CLK) begin
      if (ALUSrcB)
         alu_out <= {4'd0, din} >> 6;
      else if (ALUOp == 3'd7)
         alu_out <= 16'h8001;
      else
         alu_out <= 16'(ALUOp) + 16'd5;
   end

   typedef struct {
      logic [15:0] hdr;
      logic [15:0] imm;
      logic [2:0]  op;
      logic        srcb;
      logic [1:0]  nb;
      logic        sh;
      logic [11:0] din;
      logic [15:0] res;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [15:0] d);
      @(negedge CLK);
      instr_in    = d;
      instr_valid = 1'b1;
      chk("ready_at_send", 32'(instr_ready), 32'd1);
      @(posedge CLK);
      #1;
      instr_valid = 1'b0;
   endtask

   task automatic wait_rv(output int lat);
      lat = 0;
      while (!result_valid && lat < 40) begin
         @(posedge CLK);
         #1;
         lat++;
      end
   endtask

   task automatic release_result();
      @(negedge CLK);
      result_ready = 1'b1;
      @(posedge CLK);
      #1;
      result_ready = 1'b0;
      chk("rv_cleared", 32'(result_valid), 32'd0);
      chk("busy_cleared", 32'(busy), 32'd0);
   endtask

   initial begin
      int lat;
      int lat1;
      int lat15;
      int seen;
      logic [15:0] held;

      vecs[0] = '{16'h1400, 16'h0216, 3'd0, 1'b1, 2'd1, 1'b0, 12'd534,  16'd8};
      vecs[1] = '{16'h0000, 16'h0000, 3'd0, 1'b0, 2'd0, 1'b0, 12'd0,    16'd5};
      vecs[2] = '{16'hE000, 16'h0000, 3'd7, 1'b0, 2'd0, 1'b0, 12'd0,    16'h8001};
      vecs[3] = '{16'h7E00, 16'hFFFF, 3'd3, 1'b1, 2'd3, 1'b1, 12'hFFF,  16'h003F};
      vecs[4] = '{16'h4A00, 16'h0000, 3'd2, 1'b0, 2'd2, 1'b1, 12'd0,    16'd7};
      vecs[5] = '{16'hB000, 16'hA040, 3'd5, 1'b1, 2'd0, 1'b0, 12'h040,  16'd1};

      #3;
      chk("rst_ready", 32'(instr_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rv", 32'(result_valid), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_ctrl", {ALUOp, ALUSrcB, numBits, immShift, din}, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      @(posedge CLK);
      #1;
      chk("ready_after_release", 32'(instr_ready), 32'd1);

      @(negedge CLK);
      result_ready = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      chk("idle_ready_noeffect_busy", 32'(busy), 32'd0);
      chk("idle_ready_noeffect_rv", 32'(result_valid), 32'd0);
      result_ready = 1'b0;

      for (int i = 0; i < 6; i++) begin
         send(vecs[i].hdr);
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
         chk($sformatf("v%0d_imm_state", i), 32'(instr_ready), 32'(vecs[i].srcb));
         if (vecs[i].srcb) begin
            repeat (2) @(posedge CLK);
            #1;
            chk($sformatf("v%0d_imm_waits", i), 32'(instr_ready), 32'd1);
            send(vecs[i].imm);
         end
         wait_rv(lat);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
         chk($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].res));
         chk($sformatf("v%0d_ctrl", i), {ALUOp, ALUSrcB, numBits, immShift, din},
             {vecs[i].op, vecs[i].srcb, vecs[i].nb, vecs[i].sh, vecs[i].din});
         release_result();
         chk($sformatf("v%0d_result_held", i), 32'(result), 32'(vecs[i].res));
      end

      send(16'h0001);
      chk("err_pulse", 32'(err), 32'd1);
      chk("err_busy", 32'(busy), 32'd0);
      @(posedge CLK);
      #1;
      chk("err_one_cycle", 32'(err), 32'd0);
      send(16'h0000);
      wait_rv(lat);
      chk("after_err_latency", 32'(lat), 32'd3);
      chk("after_err_result", 32'(result), 32'd5);

      @(negedge CLK);
      instr_in    = 16'h2000;
      instr_valid = 1'b1;
      held = result;
      seen = 0;
      repeat (10) begin
         @(posedge CLK);
         #1;
         if (result !== held || instr_ready !== 1'b0 || result_valid !== 1'b1) seen++;
      end
      chk("backpressure_stable", 32'(seen), 32'd0);
      chk("backpressure_no_consume", {ALUOp, din}, 32'd0);
      @(negedge CLK);
      instr_valid  = 1'b0;
      result_ready = 1'b1;
      @(posedge CLK);
      #1;
      result_ready = 1'b0;
      chk("backpressure_release_busy", 32'(busy), 32'd0);
      chk("backpressure_release_rv", 32'(result_valid), 32'd0);

      send(16'h1400);
      #2;
      RST_N = 1'b0;
      #1;
      chk("rst_imm_ctrl", {ALUOp, ALUSrcB, numBits, immShift, din}, 32'd0);
      chk("rst_imm_busy_ready", {busy, instr_ready, result_valid}, 32'd0);
      chk("rst_imm_result", 32'(result), 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      seen = 0;
      repeat (8) begin
         @(posedge CLK);
         #1;
         if (result_valid || busy) seen++;
      end
      chk("rst_imm_no_result", 32'(seen), 32'd0);

      send(16'h0000);
      @(posedge CLK);
      #2;
      chk("exec_busy_before_rst", 32'(busy), 32'd1);
      RST_N = 1'b0;
      #1;
      chk("rst_exec_outputs", {busy, instr_ready, result_valid, err}, 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      seen = 0;
      repeat (8) begin
         @(posedge CLK);
         #1;
         if (result_valid) seen++;
      end
      chk("rst_exec_no_result", 32'(seen), 32'd0);

      @(negedge CLK);
      instr_in  = 16'h0000;
      aux_valid = 1'b1;
      chk("aux_ready", {r1_ready, r15_ready}, 32'd3);
      @(posedge CLK);
      #1;
      aux_valid = 1'b0;
      lat = 0;
      lat1 = -1;
      lat15 = -1;
      while ((lat1 < 0 || lat15 < 0) && lat < 40) begin
         @(posedge CLK);
         #1;
         lat++;
         if (r1_rv && lat1 < 0) lat1 = lat;
         if (r15_rv && lat15 < 0) lat15 = lat;
      end
      chk("latency_exec1", 32'(lat1), 32'd2);
      chk("latency_exec15", 32'(lat15), 32'd16);
      chk("aux_results", {r1_res, r15_res}, 32'h00A5_00A5);
      @(negedge CLK);
      aux_ready = 1'b1;
      @(posedge CLK);
      #1;
      aux_ready = 1'b0;
      chk("aux_idle", {r1_busy, r15_busy, r1_rv, r15_rv}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_controller.md
ALU_CONTROLLER -- requirements
Module: alu_controller

Interface
REQ-001 Parameter EXEC_CYCLES, default 2: cycles the ALU controls are held before ALUOut is sampled; legal range 1..15.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 instr_in  input  16  instruction word (header or immediate beat).
REQ-005 instr_valid  input  1  instr_in valid.
REQ-006 instr_ready  output  1  controller accepts instr_in this cycle.
REQ-007 ALUOut  input  16  signed result from ALU/ImmGen datapath.
REQ-008 ALUOp  output  3  ALU operation select to datapath.
REQ-009 ALUSrcB  output  1  1 = ALU B operand from ImmGen, 0 = from B register.
REQ-010 din  output  12  raw immediate to ImmGen.
REQ-011 numBits  output  2  ImmGen width select.
REQ-012 immShift  output  1  ImmGen shift select.
REQ-013 result  output  16  captured ALUOut.
REQ-014 result_valid  output  1  result holds a completed operation.
REQ-015 result_ready  input  1  consumer accepts result.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 err  output  1  one-cycle pulse on a rejected header.

Function
REQ-018 Header format SHALL be: [15:13] ALUOp, [12] ALUSrcB, [11:10] numBits, [9] immShift, [8:0] reserved, must be zero.
REQ-019 FSM states SHALL be IDLE, IMM, EXEC, RESP.
REQ-020 instr_ready SHALL be 1 in IDLE and IMM only; a beat transfers on instr_valid & instr_ready at a rising edge.
REQ-021 IDLE: header accepted with reserved != 0 -> err = 1 next cycle, header dropped, stay IDLE.
REQ-022 IDLE: valid header with ALUSrcB = 1 -> register ALUOp/numBits/immShift/ALUSrcB, go IMM; with ALUSrcB = 0 -> register fields, din = 0, go EXEC.
REQ-023 IMM: accepted beat -> din = instr_in[11:0] (bits [15:12] ignored), go EXEC; no timeout, IMM waits indefinitely.
REQ-024 EXEC: 4-bit counter loads EXEC_CYCLES-1 on entry, decrements each cycle; at zero, result <= ALUOut, result_valid <= 1, go RESP.
REQ-025 Latency: last accepted beat to result_valid high SHALL be exactly EXEC_CYCLES+1 cycles.
REQ-026 All control outputs SHALL be registered and stable from EXEC entry until the next header is accepted.
REQ-027 RESP: result_valid & result_ready -> result_valid = 0 next cycle, go IDLE; result holds value until next capture.
REQ-028 instr_valid during EXEC/RESP SHALL be ignored (instr_ready = 0); no queuing.
REQ-029 result_ready while result_valid = 0 SHALL have no effect.
REQ-030 ALUOut SHALL be captured unmodified, 16 bits, no sign or width conversion.

Reset
REQ-031 RST_N low SHALL immediately force state IDLE, counter 0, ALUOp 0, ALUSrcB 0, din 0, numBits 0, immShift 0, result 0, result_valid 0, err 0, busy 0.
REQ-032 instr_ready SHALL be 0 while RST_N is low and 1 from the first edge after release.
REQ-033 Reset asserted mid-operation (IMM, EXEC, RESP) SHALL abandon the operation with no result_valid pulse.

Structure
REQ-034 Package alu_ctrl_pkg SHALL hold state encoding, header field bit positions, reserved mask, and EXEC_CYCLES range limits.
REQ-035 One sub-module alu_instr_decode (combinational header field split + reserved check) SHALL be used; FSM, counter, and output registers stay in alu_controller.

Verification (bench uses behavioural ALU stub, ALUOut = f(controls) after 1 cycle)
REQ-036 Header 0x1400 (ALUOp 0, SrcB 1, numBits 1), imm beat 0x0216 -> din = 534, numBits = 1, ALUSrcB = 1; stub ALUOut = 8 -> result = 8, result_valid exactly EXEC_CYCLES+1 cycles after imm beat.
REQ-037 Header 0x0000 (SrcB 0), stub ALUOut = 5 -> no IMM state, din = 0, result = 5 after 3 cycles (EXEC_CYCLES = 2).
REQ-038 Header 0x0001 (reserved set) -> err pulse 1 cycle, busy stays 0, next valid header processed normally.
REQ-039 result_ready held 0 for 10 cycles with instr_valid = 1 -> result stable, instr_ready = 0, no new beat consumed; ready = 1 -> IDLE next cycle.
REQ-040 RST_N pulsed low during EXEC and during IMM -> all outputs at reset values asynchronously, no result_valid afterward.
REQ-041 EXEC_CYCLES = 1 and 15 builds -> latency 2 and 16 cycles respectively.
